irq_req_collector: RTL and testbench

Upstream stage of the 8-to-3 priority encoder path. It synchronizes eight raw asynchronous request lines and detects their rising edges. Detected edges are held in a sticky pending register, which is masked and fed to a highest-index priority pick. A single registered request ID (irq_id, irq_valid) is presented to the consumer and held stable until acknowledged.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_prio_pick.sv | 22 ++
 rtl/irq_req_collector.sv | 125 ++++++++++++
 tb/tb_irq_req_collector.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and helpers for the interrupt request collector.
package irq_pkg;

  localparam int N_IRQ           = 8;
  localparam int IRQ_ID_W        = 3;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } irq_state_e;

  function automatic logic [N_IRQ-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
    id_onehot     = '0;
    id_onehot[id] = 1'b1;
  endfunction

endpackage

// File: rtl/irq_prio_pick.sv
// Combinational highest-index pick over an 8-bit vector; any=0 when nothing is set.
module irq_prio_pick
  import irq_pkg::*;
(
  input  logic [N_IRQ-1:0]    vec,
  output logic [IRQ_ID_W-1:0] id,
  output logic                any
);

  // Ascending scan: the last set bit seen is the highest index, which wins.
  always_comb begin
    id  = '0;
    any = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (vec[i]) begin
        id  = i[IRQ_ID_W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_req_collector.sv
// Synchronizes raw request lines, latches rising edges as sticky pending bits and
// presents one ID at a time until acked. Optional overflow flags: IRQ_OVERFLOW_EN.
module irq_req_collector
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_IRQ-1:0]    req_in,
  input  logic [N_IRQ-1:0]    mask,
  input  logic                ack,
  output logic [N_IRQ-1:0]    pend,
  output logic                irq_valid,
  output logic [IRQ_ID_W-1:0] irq_id
`ifdef IRQ_OVERFLOW_EN
  ,
  output logic [N_IRQ-1:0]    ovf
`endif
);

  // Handshake: irq_id is meaningful while irq_valid=1 and is held until a one-cycle
  // ack; the collector then drops irq_valid for at least one cycle before the next ID.

  // Reset asserts asynchronously everywhere but releases on a clock edge.
  logic [1:0] rst_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= '0;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_int_n = rst_q[1];

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] rise;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  logic [IRQ_ID_W-1:0] pick_id;
  logic                pick_any;

  irq_prio_pick u_pick (
    .vec (pend & mask),
    .id  (pick_id),
    .any (pick_any)
  );

  irq_state_e          state, state_nxt;
  logic                valid_nxt;
  logic [IRQ_ID_W-1:0] id_nxt;
  logic [N_IRQ-1:0]    clr;
  logic [N_IRQ-1:0]    pend_nxt;

  always_comb begin
    state_nxt = state;
    valid_nxt = irq_valid;
    id_nxt    = irq_id;
    clr       = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          id_nxt    = pick_id;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          clr       = id_onehot(irq_id);
          valid_nxt = 1'b0;
          state_nxt = GAP;
        end else if (!mask[irq_id]) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // A new edge on the bit being acked wins, so the request is not lost.
  assign pend_nxt = (pend & ~clr) | rise;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
      pend      <= '0;
    end else begin
      state     <= state_nxt;
      irq_valid <= valid_nxt;
      irq_id    <= id_nxt;
      pend      <= pend_nxt;
    end
  end

`ifdef IRQ_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) ovf <= '0;
    else            ovf <= (ovf & ~clr) | (rise & pend & ~clr);
  end
`endif

endmodule

// File: tb/tb_irq_req_collector.sv
// Bench for irq_req_collector: directed vector table, hand sequences and random traffic
// checked against a behavioural model driven by a per-line delay history.
module tb_irq_req_collector;
  import irq_pkg::*;

  localparam int S = SYNC_STAGES_DEF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       ack;
  logic [7:0] pend;
  logic       irq_valid;
  logic [2:0] irq_id;
`ifdef IRQ_OVERFLOW_EN
  logic [7:0] ovf;
`endif

  always #5 clk = ~clk;

  irq_req_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask      (mask),
    .ack       (ack),
    .pend      (pend),
    .irq_valid (irq_valid),
    .irq_id    (irq_id)
`ifdef IRQ_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard entry: {valid, id, pend}
  logic [11:0] exp_q[$];

  typedef struct {
    logic [7:0] req;
    logic [7:0] msk;
    logic       ak;
    logic [7:0] e_pend;
    logic       e_valid;
    logic [2:0] e_id;
  } vec_t;

  vec_t tbl[42];

  // Reference model state
  logic [7:0] hist[8];
  logic [7:0] m_pend;
  logic [7:0] m_ovf;
  logic       m_valid;
  logic       m_gap;
  logic [2:0] m_id;

  function automatic vec_t v(input logic [7:0] r, input logic [7:0] m, input logic a,
                             input logic [7:0] p, input logic vl, input logic [2:0] id);
    vec_t t;
    t.req = r; t.msk = m; t.ak = a; t.e_pend = p; t.e_valid = vl; t.e_id = id;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) hist[i] = '0;
    m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_gap = 1'b0; m_id = '0;
  endtask

  // One clock edge of the rules: a line's request counts as new when it was seen high
  // S edges ago and low the edge before; the presentation rules follow the datasheet.
  task automatic model_edge();
    logic [7:0] rise;
    logic [7:0] clr;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = req_in;
    rise = hist[S] & ~hist[S+1];
    clr  = '0;
    if (m_valid) begin
      if (ack) begin
        clr[m_id] = 1'b1;
        m_valid   = 1'b0;
        m_gap     = 1'b1;
      end else if (!mask[m_id]) begin
        m_valid = 1'b0;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if ((m_pend & mask) != 8'h00) begin
      for (int i = 0; i < 8; i++) if (m_pend[i] && mask[i]) m_id = i[2:0];
      m_valid = 1'b1;
    end
    m_ovf  = (m_ovf & ~clr) | (rise & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | rise;
  endtask

  task automatic step();
    logic [11:0] e;
    @(posedge clk);
    model_edge();
    exp_q.push_back({m_valid, m_id, m_pend});
    #1;
    e = exp_q.pop_front();
    chk("model_valid", 32'(irq_valid), 32'(e[11]));
    chk("model_id",    32'(irq_id),    32'(e[10:8]));
    chk("model_pend",  32'(pend),      32'(e[7:0]));
`ifdef IRQ_OVERFLOW_EN
    chk("model_ovf",   32'(ovf),       32'(m_ovf));
`endif
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req_in = '0;
    mask   = 8'hFF;
    ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_clear();
    chk("reset_pend",  32'(pend),      0);
    chk("reset_valid", 32'(irq_valid), 0);
    chk("reset_id",    32'(irq_id),    0);
`ifdef IRQ_OVERFLOW_EN
    chk("reset_ovf",   32'(ovf),       0);
`endif
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] m, input logic a);
    req_in = r; mask = m; ack = a;
    step();
  endtask

  initial begin
    // Directed table: single request, priority order, no pre-emption, mask withdraw,
    // ack ignored in IDLE.
    tbl[0]  = v(8'h08, 8'hFF, 0, 8'h00, 0, 3'd0);
    tbl[1]  = v(8'h08, 8'hFF, 0, 8'h00, 0, 3'd0);
    tbl[2]  = v(8'h08, 8'hFF, 0, 8'h08, 0, 3'd0);
    tbl[3]  = v(8'h08, 8'hFF, 0, 8'h08, 1, 3'd3);
    tbl[4]  = v(8'h00, 8'hFF, 1, 8'h00, 0, 3'd3);
    tbl[5]  = v(8'h00, 8'hFF, 0, 8'h00, 0, 3'd3);
    tbl[6]  = v(8'h00, 8'hFF, 0, 8'h00, 0, 3'd3);
    tbl[7]  = v(8'h00, 8'hFF, 0, 8'h00, 0, 3'd3);
    tbl[8]  = v(8'h24, 8'hFF, 0, 8'h00, 0, 3'd3);
    tbl[9]  = v(8'h24, 8'hFF, 0, 8'h00, 0, 3'd3);
    tbl[10] = v(8'h24, 8'hFF, 0, 8'h24, 0, 3'd3);
    tbl[11] = v(8'h24, 8'hFF, 0, 8'h24, 1, 3'd5);
    tbl[12] = v(8'h24, 8'hFF, 1, 8'h04, 0, 3'd5);
    tbl[13] = v(8'h00, 8'hFF, 0, 8'h04, 0, 3'd5);
    tbl[14] = v(8'h00, 8'hFF, 0, 8'h04, 1, 3'd2);
    tbl[15] = v(8'h80, 8'hFF, 0, 8'h04, 1, 3'd2);
    tbl[16] = v(8'h80, 8'hFF, 0, 8'h04, 1, 3'd2);
    tbl[17] = v(8'h80, 8'hFF, 0, 8'h84, 1, 3'd2);
    tbl[18] = v(8'h80, 8'hFF, 0, 8'h84, 1, 3'd2);
    tbl[19] = v(8'h00, 8'hFF, 1, 8'h80, 0, 3'd2);
    tbl[20] = v(8'h00, 8'hFF, 0, 8'h80, 0, 3'd2);
    tbl[21] = v(8'h00, 8'hFF, 0, 8'h80, 1, 3'd7);
    tbl[22] = v(8'h00, 8'hFF, 1, 8'h00, 0, 3'd7);
    tbl[23] = v(8'h00, 8'hFF, 0, 8'h00, 0, 3'd7);
    tbl[24] = v(8'h10, 8'hEF, 0, 8'h00, 0, 3'd7);
    tbl[25] = v(8'h10, 8'hEF, 0, 8'h00, 0, 3'd7);
    tbl[26] = v(8'h10, 8'hEF, 0, 8'h10, 0, 3'd7);
    tbl[27] = v(8'h00, 8'hEF, 0, 8'h10, 0, 3'd7);
    tbl[28] = v(8'h00, 8'hFF, 0, 8'h10, 1, 3'd4);
    tbl[29] = v(8'h00, 8'hEF, 0, 8'h10, 0, 3'd4);
    tbl[30] = v(8'h00, 8'hEF, 0, 8'h10, 0, 3'd4);
    tbl[31] = v(8'h01, 8'h00, 0, 8'h10, 0, 3'd4);
    tbl[32] = v(8'h01, 8'h00, 0, 8'h10, 0, 3'd4);
    tbl[33] = v(8'h01, 8'h00, 0, 8'h11, 0, 3'd4);
    tbl[34] = v(8'h00, 8'h00, 1, 8'h11, 0, 3'd4);
    tbl[35] = v(8'h00, 8'h00, 1, 8'h11, 0, 3'd4);
    tbl[36] = v(8'h00, 8'hFF, 0, 8'h11, 1, 3'd4);
    tbl[37] = v(8'h00, 8'hFF, 1, 8'h01, 0, 3'd4);
    tbl[38] = v(8'h00, 8'hFF, 0, 8'h01, 0, 3'd4);
    tbl[39] = v(8'h00, 8'hFF, 0, 8'h01, 1, 3'd0);
    tbl[40] = v(8'h00, 8'hFF, 1, 8'h00, 0, 3'd0);
    tbl[41] = v(8'h00, 8'hFF, 0, 8'h00, 0, 3'd0);

    do_reset();

    for (int i = 0; i < 42; i++) begin
      drive(tbl[i].req, tbl[i].msk, tbl[i].ak);
      chk($sformatf("tbl%0d_pend", i),  32'(pend),      32'(tbl[i].e_pend));
      chk($sformatf("tbl%0d_valid", i), 32'(irq_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_id", i),    32'(irq_id),    32'(tbl[i].e_id));
    end

    // Repeated edge on a pending line, ack, then asynchronous reset mid-presentation.
    do_reset();
    drive(8'h40, 8'hFF, 0);
    drive(8'h40, 8'hFF, 0);
    drive(8'h00, 8'hFF, 0);
    drive(8'h00, 8'hFF, 0);
    chk("seq6_valid", 32'(irq_valid), 1);
    chk("seq6_id",    32'(irq_id),    6);
    drive(8'h40, 8'hFF, 0);
    drive(8'h40, 8'hFF, 0);
    drive(8'h00, 8'hFF, 0);
    chk("seq6_pend_merged", 32'(pend), 32'h40);
`ifdef IRQ_OVERFLOW_EN
    chk("seq6_ovf_set", 32'(ovf), 32'h40);
`endif
    drive(8'h00, 8'hFF, 1);
    chk("seq6_pend_acked", 32'(pend), 0);
`ifdef IRQ_OVERFLOW_EN
    chk("seq6_ovf_clr", 32'(ovf), 0);
`endif
    drive(8'h00, 8'hFF, 0);
    drive(8'h40, 8'hFF, 0);
    drive(8'h40, 8'hFF, 0);
    drive(8'h00, 8'hFF, 0);
    drive(8'h00, 8'hFF, 0);
    chk("seq6_re_valid", 32'(irq_valid), 1);
    chk("seq6_re_id",    32'(irq_id),    6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(irq_valid), 0);
    chk("async_rst_id",    32'(irq_id),    0);
    chk("async_rst_pend",  32'(pend),      0);
`ifdef IRQ_OVERFLOW_EN
    chk("async_rst_ovf",   32'(ovf),       0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [7:0] tog;
      tog = '0;
      for (int b = 0; b < 8; b++) tog[b] = ($urandom_range(0, 5) == 0);
      req_in = req_in ^ tog;
      mask   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      ack    = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
